// File: rtl/dma_eastbridge_arbiter.sv
// Memory-side arbiter for the Eastbridge DMA bus: round-robin grant with a burst
// cap, muxes the owner's request onto the single RAM DMA port, returns read strobes.
module dma_eastbridge_arbiter #(
    parameter int N_DEV     = 4,
    parameter int MAX_BURST = 8
) (
    input  logic                DMA_CLOCK,
    input  logic                DMA_RESET,
    input  logic [N_DEV-1:0]    DEV_want,
    output logic [N_DEV-1:0]    DEV_access,
    input  logic [16*N_DEV-1:0] DEV_addr,
    input  logic [16*N_DEV-1:0] DEV_out,
    input  logic [N_DEV-1:0]    DEV_wren,
    output logic [15:0]         DEV_data,
    output logic [N_DEV-1:0]    DEV_rvalid,
    output logic [15:0]         RAM_addr,
    output logic [15:0]         RAM_wdata,
    output logic                RAM_wren,
    input  logic [15:0]         RAM_rdata
);
    localparam int IDX_W = $clog2(N_DEV);
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N_DEV - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state;
    logic [IDX_W-1:0] gidx;
    logic [IDX_W-1:0] last;
    logic [CNT_W-1:0] burst_cnt;
    logic [IDX_W-1:0] rot_idx;
    logic [IDX_W-1:0] cand;
    logic             rot_found;
    logic             others;
    logic             keep;

    // Scan last+1, last+2, ... wrapping, so 'last' itself is considered last.
    always_comb begin
        rot_idx   = '0;
        rot_found = 1'b0;
        cand      = last;
        for (int k = 0; k < N_DEV; k++) begin
            cand = (cand == IDX_TOP) ? '0 : cand + 1'b1;
            if (!rot_found && DEV_want[cand]) begin
                rot_found = 1'b1;
                rot_idx   = cand;
            end
        end
    end

    assign others = |(DEV_want & ~DEV_access);
    assign keep   = (state == GRANT) && DEV_want[gidx] &&
                    ((burst_cnt != CNT_CAP) || !others);

    always_ff @(posedge DMA_CLOCK) begin
        if (DMA_RESET) begin
            state      <= IDLE;
            gidx       <= '0;
            last       <= IDX_TOP;
            burst_cnt  <= '0;
            DEV_access <= '0;
            DEV_rvalid <= '0;
        end else begin
            DEV_rvalid <= (state == GRANT && !RAM_wren) ? DEV_access : '0;
            if (keep) begin
                // A lone owner that hits the cap just starts a fresh burst window.
                burst_cnt <= (burst_cnt == CNT_CAP) ? '0 : burst_cnt + 1'b1;
            end else if (rot_found) begin
                state      <= GRANT;
                gidx       <= rot_idx;
                last       <= rot_idx;
                burst_cnt  <= '0;
                DEV_access <= N_DEV'(1) << rot_idx;
            end else begin
                state      <= IDLE;
                DEV_access <= '0;
            end
        end
    end

    always_comb begin
        RAM_addr  = '0;
        RAM_wdata = '0;
        RAM_wren  = 1'b0;
        if (state == GRANT) begin
            RAM_addr  = DEV_addr[16*gidx +: 16];
            RAM_wdata = DEV_out[16*gidx +: 16];
            RAM_wren  = DEV_wren[gidx];
        end
    end

    assign DEV_data = RAM_rdata;

endmodule

// File: tb/tb_dma_eastbridge_arbiter.sv
// Directed and random checks of dma_eastbridge_arbiter against a bench RAM model.
module tb_dma_eastbridge_arbiter;
    localparam int N  = 4;
    localparam int MB = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    want = '0;
    logic [N-1:0]    wren = '0;
    logic [16*N-1:0] addr = '0;
    logic [16*N-1:0] wdat = '0;
    logic [N-1:0]    access, rvalid;
    logic [15:0]     dev_data, ram_addr, ram_wdata, ram_rdata;
    logic            ram_wren;

    logic [15:0] mem [0:65535];
    logic [15:0] shadow [0:15];
    logic [15:0] shadow_vld;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dma_eastbridge_arbiter #(.N_DEV(N), .MAX_BURST(MB)) dut (
        .DMA_CLOCK (clk),
        .DMA_RESET (rst),
        .DEV_want  (want),
        .DEV_access(access),
        .DEV_addr  (addr),
        .DEV_out   (wdat),
        .DEV_wren  (wren),
        .DEV_data  (dev_data),
        .DEV_rvalid(rvalid),
        .RAM_addr  (ram_addr),
        .RAM_wdata (ram_wdata),
        .RAM_wren  (ram_wren),
        .RAM_rdata (ram_rdata)
    );

    // RAM with one cycle read latency
    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic step;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; want = '0; wren = 4'b1111;
        addr = 64'h4444_3333_2222_1111;
        wdat = 64'hDDDD_CCCC_BBBB_AAAA;
        step; step;
        total++;
        if (access !== '0 || rvalid !== '0) begin
            bad++; $display("FAIL reset_hold access=%b rvalid=%b, wanted 0000/0000", access, rvalid);
        end
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step;
            total++;
            if (access !== '0 || ram_wren !== 1'b0 || ram_addr !== 16'h0 || ram_wdata !== 16'h0 || rvalid !== '0) begin
                bad++;
                $display("FAIL idle c=%0d access=%b wren=%b addr=%h wdata=%h rvalid=%b, wanted all 0",
                         c, access, ram_wren, ram_addr, ram_wdata, rvalid);
            end
        end
        total++;
        if (dev_data !== ram_rdata) begin
            bad++; $display("FAIL data_passthru got=%h wanted=%h", dev_data, ram_rdata);
        end
        want = 4'b0100;
        step;
        total++;
        if (access !== 4'b0100 || ram_addr !== 16'h3333 || ram_wdata !== 16'hCCCC || ram_wren !== 1'b1) begin
            bad++;
            $display("FAIL first_grant access=%b addr=%h wdata=%h wren=%b, wanted 0100/3333/cccc/1",
                     access, ram_addr, ram_wdata, ram_wren);
        end
        want = '0;
        step;
        total++;
        if (access !== '0) begin
            bad++; $display("FAIL drop_want access=%b wanted 0000", access);
        end
    endtask

    task automatic test_write_read;
        wren = 4'b0010; want = 4'b0010;
        addr[16 +: 16] = 16'h1234;
        wdat[16 +: 16] = 16'hBEEF;
        step;
        total++;
        if (access !== 4'b0010 || ram_wren !== 1'b1 || ram_addr !== 16'h1234 || ram_wdata !== 16'hBEEF) begin
            bad++;
            $display("FAIL wr_cycle access=%b wren=%b addr=%h wdata=%h, wanted 0010/1/1234/beef",
                     access, ram_wren, ram_addr, ram_wdata);
        end
        step;
        wren = '0; want = '0;
        #1;
        total++;
        if (access !== 4'b0010 || ram_wren !== 1'b0 || rvalid !== '0) begin
            bad++;
            $display("FAIL rd_cycle access=%b wren=%b rvalid=%b, wanted 0010/0/0000", access, ram_wren, rvalid);
        end
        step;
        total++;
        if (access !== '0 || rvalid !== 4'b0010 || dev_data !== 16'hBEEF) begin
            bad++;
            $display("FAIL rd_return access=%b rvalid=%b data=%h, wanted 0000/0010/beef", access, rvalid, dev_data);
        end
        step;
        total++;
        if (rvalid !== '0) begin
            bad++; $display("FAIL rd_once rvalid=%b wanted 0000", rvalid);
        end
    endtask

    task automatic test_round_robin;
        logic [N-1:0] exp_a, prev_a;
        rst = 1'b1; want = 4'b1111; wren = '0;
        step;
        rst = 1'b0;
        prev_a = '0;
        for (int c = 0; c < 4 * MB * 2; c++) begin
            step;
            exp_a = N'(1) << ((c / MB) % N);
            total++;
            if (access !== exp_a || rvalid !== prev_a) begin
                bad++;
                $display("FAIL rr c=%0d access=%b rvalid=%b, wanted %b/%b", c, access, rvalid, exp_a, prev_a);
            end
            prev_a = exp_a;
        end
    endtask

    task automatic test_single;
        int held;
        logic [N-1:0] a;
        rst = 1'b1; want = 4'b1000; wren = '0;
        step;
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step;
            total++;
            if (access !== 4'b1000) begin
                bad++; $display("FAIL solo c=%0d access=%b wanted 1000", c, access);
            end
        end
        want = 4'b1001;
        held = 0;
        a = '0;
        for (int c = 0; c < 10; c++) begin
            step;
            a = access;
            if (a !== 4'b1000) break;
            held++;
        end
        total++;
        if (a !== 4'b0001 || held > MB) begin
            bad++; $display("FAIL contend access=%b held=%0d, wanted 0001 within %0d", a, held, MB);
        end
    endtask

    task automatic test_reset_mid;
        rst = 1'b1; want = '0; wren = '0;
        step;
        rst = 1'b0; want = 4'b0100;
        step;
        total++;
        if (access !== 4'b0100) begin
            bad++; $display("FAIL mid_grant access=%b wanted 0100", access);
        end
        step;
        total++;
        if (access !== 4'b0100 || rvalid !== 4'b0100) begin
            bad++; $display("FAIL mid_burst access=%b rvalid=%b, wanted 0100/0100", access, rvalid);
        end
        rst = 1'b1;
        step;
        total++;
        if (access !== '0 || rvalid !== '0) begin
            bad++; $display("FAIL mid_reset access=%b rvalid=%b, wanted 0000/0000", access, rvalid);
        end
        rst = 1'b0; want = 4'b0101;
        step;
        total++;
        if (access !== 4'b0001 || rvalid !== '0) begin
            bad++; $display("FAIL post_reset access=%b rvalid=%b, wanted 0001/0000", access, rvalid);
        end
    endtask

    task automatic test_random;
        int waitc [N];
        int g;
        logic pend_vld;
        int pend_dev;
        logic [3:0] pend_addr;
        logic [N-1:0] exp_rv;
        logic [15:0] ea, ed;
        logic ew;
        rst = 1'b1; want = '0; wren = '0;
        step;
        rst = 1'b0;
        shadow_vld = '0;
        pend_vld = 1'b0; pend_dev = 0; pend_addr = '0;
        for (int i = 0; i < N; i++) waitc[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            step;
            exp_rv = pend_vld ? (N'(1) << pend_dev) : '0;
            total++;
            if (rvalid !== exp_rv) begin
                bad++; $display("FAIL rnd_rvalid c=%0d got=%b wanted=%b", c, rvalid, exp_rv);
            end
            if (pend_vld && shadow_vld[pend_addr]) begin
                total++;
                if (dev_data !== shadow[pend_addr]) begin
                    bad++;
                    $display("FAIL rnd_data c=%0d addr=%0d got=%h wanted=%h", c, pend_addr, dev_data, shadow[pend_addr]);
                end
            end
            total++;
            if ((access & (access - 1'b1)) !== '0 || (access & ~want) !== '0) begin
                bad++; $display("FAIL rnd_onehot c=%0d access=%b want=%b", c, access, want);
            end
            g = -1;
            for (int i = 0; i < N; i++) begin
                if (access[i]) g = i;
                waitc[i] = (want[i] && !access[i]) ? waitc[i] + 1 : 0;
                total++;
                if (waitc[i] > (N - 1) * MB) begin
                    bad++; $display("FAIL rnd_starve c=%0d dev=%0d waited=%0d, limit %0d", c, i, waitc[i], (N - 1) * MB);
                end
            end
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(7) == 0) want[i] = ~want[i];
                addr[16*i +: 16] = 16'($urandom_range(15));
                wdat[16*i +: 16] = 16'($urandom);
                wren[i] = 1'($urandom_range(1));
            end
            #1;
            ea = '0; ed = '0; ew = 1'b0;
            if (g >= 0) begin
                ea = addr[16*g +: 16];
                ed = wdat[16*g +: 16];
                ew = wren[g];
            end
            total++;
            if (ram_addr !== ea || ram_wdata !== ed || ram_wren !== ew) begin
                bad++;
                $display("FAIL rnd_mux c=%0d addr=%h wdata=%h wren=%b, wanted %h/%h/%b",
                         c, ram_addr, ram_wdata, ram_wren, ea, ed, ew);
            end
            pend_vld = 1'b0;
            if (g >= 0 && ew) begin
                shadow[ea[3:0]] = ed;
                shadow_vld[ea[3:0]] = 1'b1;
            end else if (g >= 0) begin
                pend_vld = 1'b1; pend_dev = g; pend_addr = ea[3:0];
            end
        end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_round_robin;
        test_single;
        test_reset_mid;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
